branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters for IF-stage prediction,
// plus EX-stage mispredict detection, redirect, table training and perf counters.
`default_nettype none

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        pred_taken_f,
    output logic [31:0] pred_target_f,
    input  logic        res_valid_e,
    input  logic        res_is_branch_e,
    input  logic [31:0] res_pc_e,
    input  logic        res_taken_e,
    input  logic [31:0] res_target_e,
    input  logic        res_pred_taken_e,
    input  logic [31:0] res_pred_target_e,
    input  logic        stall_e,
    output logic        mispredict_e,
    output logic [31:0] redirect_pc_e,
    output logic        flush,
    output logic [31:0] cnt_branches,
    output logic [31:0] cnt_mispredicts
);

    localparam int TAG_W = 30 - INDEX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [INDEX_W-1:0] f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit;
    logic [31:0]        f_seq_pc;

    logic [INDEX_W-1:0] e_idx;
    logic [TAG_W-1:0]   e_tag;
    logic               e_hit;
    logic [31:0]        e_seq_pc;
    logic               nonbranch_taken;
    logic               update_en;

    // Fetch-side lookup reads only registered state, so same-cycle training is not bypassed.
    assign f_idx    = pc_f[INDEX_W+1:2];
    assign f_tag    = pc_f[31:INDEX_W+2];
    assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_seq_pc = pc_f + 32'd4;

    assign pred_taken_f  = !rst && f_hit && ctr_q[f_idx][1];
    assign pred_target_f = pred_taken_f ? target_q[f_idx] : f_seq_pc;

    assign e_idx    = res_pc_e[INDEX_W+1:2];
    assign e_tag    = res_pc_e[31:INDEX_W+2];
    assign e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_seq_pc = res_pc_e + 32'd4;

    // A non-branch that fetch treated as taken must fall through to pc+4.
    assign nonbranch_taken = res_valid_e && !res_is_branch_e && res_pred_taken_e;

    assign mispredict_e = nonbranch_taken ||
                          (res_valid_e && ((res_taken_e != res_pred_taken_e) ||
                                           (res_taken_e && (res_target_e != res_pred_target_e))));
    assign redirect_pc_e = (res_taken_e && !nonbranch_taken) ? res_target_e : e_seq_pc;
    assign flush         = mispredict_e;

    assign update_en = res_valid_e && !stall_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (update_en) begin
            if (res_is_branch_e) begin
                cnt_branches <= cnt_branches + 32'd1;
                if (e_hit) begin
                    if (res_taken_e) begin
                        if (ctr_q[e_idx] != 2'b11)
                            ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
                        target_q[e_idx] <= res_target_e;
                    end else if (ctr_q[e_idx] != 2'b00) begin
                        ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
                    end
                end else if (res_taken_e) begin
                    valid_q[e_idx]  <= 1'b1;
                    tag_q[e_idx]    <= e_tag;
                    target_q[e_idx] <= res_target_e;
                    ctr_q[e_idx]    <= 2'b10;
                end
            end else if (res_pred_taken_e && e_hit) begin
                valid_q[e_idx] <= 1'b0;
            end
            if (mispredict_e)
                cnt_mispredicts <= cnt_mispredicts + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed stimulus with a queue-based scoreboard and an
// independent negedge monitor comparing every DUT output.
`default_nettype none

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        res_valid_e;
    logic        res_is_branch_e;
    logic [31:0] res_pc_e;
    logic        res_taken_e;
    logic [31:0] res_target_e;
    logic        res_pred_taken_e;
    logic [31:0] res_pred_target_e;
    logic        stall_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic        flush;
    logic [31:0] cnt_branches;
    logic [31:0] cnt_mispredicts;

    int checks = 0;
    int errors = 0;
    int step_id = 0;

    typedef struct {
        int          id;
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] cb;
        logic [31:0] cm;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_f             (pc_f),
        .pred_taken_f     (pred_taken_f),
        .pred_target_f    (pred_target_f),
        .res_valid_e      (res_valid_e),
        .res_is_branch_e  (res_is_branch_e),
        .res_pc_e         (res_pc_e),
        .res_taken_e      (res_taken_e),
        .res_target_e     (res_target_e),
        .res_pred_taken_e (res_pred_taken_e),
        .res_pred_target_e(res_pred_target_e),
        .stall_e          (stall_e),
        .mispredict_e     (mispredict_e),
        .redirect_pc_e    (redirect_pc_e),
        .flush            (flush),
        .cnt_branches     (cnt_branches),
        .cnt_mispredicts  (cnt_mispredicts)
    );

    task automatic cmp(input int id, input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step%0d %s actual=0x%08h required=0x%08h", id, what, act, req);
        end
    endtask

    // Monitor: every queued expectation is matched against the outputs at the next negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.id, "pred_taken_f",    {31'd0, pred_taken_f}, {31'd0, e.pt});
            cmp(e.id, "pred_target_f",   pred_target_f,         e.ptgt);
            cmp(e.id, "mispredict_e",    {31'd0, mispredict_e}, {31'd0, e.mis});
            cmp(e.id, "flush",           {31'd0, flush},        {31'd0, e.mis});
            cmp(e.id, "redirect_pc_e",   redirect_pc_e,         e.redir);
            cmp(e.id, "cnt_branches",    cnt_branches,          e.cb);
            cmp(e.id, "cnt_mispredicts", cnt_mispredicts,       e.cm);
        end
    end

    task automatic step(
        input logic [31:0] pc, input logic r, input logic st,
        input logic rv, input logic rb, input logic [31:0] rpc, input logic rt,
        input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt,
        input logic ept, input logic [31:0] eptgt, input logic emis,
        input logic [31:0] eredir, input logic [31:0] ecb, input logic [31:0] ecm);
        exp_t e;
        pc_f = pc; rst = r; stall_e = st;
        res_valid_e = rv; res_is_branch_e = rb; res_pc_e = rpc; res_taken_e = rt;
        res_target_e = rtgt; res_pred_taken_e = rpt; res_pred_target_e = rptgt;
        e.id = step_id; e.pt = ept; e.ptgt = eptgt; e.mis = emis;
        e.redir = eredir; e.cb = ecb; e.cm = ecm;
        exp_q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    // No resolution in EX: redirect defaults to res_pc_e(0)+4.
    task automatic idle(input logic [31:0] pc, input logic ept, input logic [31:0] eptgt,
                        input logic [31:0] ecb, input logic [31:0] ecm);
        step(pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             ept, eptgt, 1'b0, 32'h4, ecb, ecm);
    endtask

    initial begin
        rst = 1'b1; stall_e = 1'b0; pc_f = 32'h100;
        res_valid_e = 1'b0; res_is_branch_e = 1'b0; res_pc_e = 32'h0; res_taken_e = 1'b0;
        res_target_e = 32'h0; res_pred_taken_e = 1'b0; res_pred_target_e = 32'h0;
        @(posedge clk);
        #1;
        // Reset still asserted: table empty, counters cleared.
        step(32'h100, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h104, 0, 32'h4, 0, 0);
        idle(32'h100, 0, 32'h104, 0, 0);
        // First taken resolution of 0x100 -> 0x40 mispredicts and allocates.
        step(32'h100, 0, 0, 1, 1, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40, 0, 0);
        step(32'h100, 0, 0, 1, 1, 32'h100, 1, 32'h40, 1, 32'h40,  1, 32'h40,  0, 32'h40, 1, 1);
        step(32'h100, 0, 0, 1, 1, 32'h100, 1, 32'h40, 1, 32'h40,  1, 32'h40,  0, 32'h40, 2, 1);
        step(32'h100, 0, 0, 1, 1, 32'h100, 1, 32'h40, 1, 32'h40,  1, 32'h40,  0, 32'h40, 3, 1);
        // Not taken: ctr 11 -> 10, still predicts taken.
        step(32'h100, 0, 0, 1, 1, 32'h100, 0, 32'h40, 1, 32'h40,  1, 32'h40,  1, 32'h104, 4, 1);
        idle(32'h100, 1, 32'h40, 5, 2);
        // Second not taken: ctr 10 -> 01, now predicts not taken.
        step(32'h100, 0, 0, 1, 1, 32'h100, 0, 32'h40, 1, 32'h40,  1, 32'h40,  1, 32'h104, 5, 2);
        idle(32'h100, 0, 32'h104, 6, 3);
        // Alias 0x140 (same index) overwrites the entry.
        step(32'h100, 0, 0, 1, 1, 32'h140, 1, 32'h80, 0, 32'h144, 0, 32'h104, 1, 32'h80, 6, 3);
        idle(32'h100, 0, 32'h104, 7, 4);
        idle(32'h140, 1, 32'h80, 7, 4);
        // Non-branch at 0x140 predicted taken: mispredict, fall through, invalidate.
        step(32'h140, 0, 0, 1, 0, 32'h140, 0, 32'h0, 1, 32'h80,   1, 32'h80,  1, 32'h144, 7, 4);
        idle(32'h140, 0, 32'h144, 7, 5);
        // Taken resolution held by stall for 3 cycles, then released.
        step(32'h200, 0, 1, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 7, 5);
        step(32'h200, 0, 1, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 7, 5);
        step(32'h200, 0, 1, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 7, 5);
        step(32'h200, 0, 0, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 7, 5);
        idle(32'h200, 1, 32'h300, 8, 6);
        // Resolution coinciding with reset is dropped.
        step(32'h100, 1, 0, 1, 1, 32'h100, 1, 32'h40, 0, 32'h104, 0, 32'h104, 1, 32'h40, 8, 6);
        idle(32'h100, 0, 32'h104, 0, 0);
        // Sequential-PC wrap-around at the top of the address space.
        idle(32'hFFFF_FFFC, 0, 32'h0, 0, 0);
        step(32'hFFFF_FFFC, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h100,
             0, 32'h0, 1, 32'h0, 0, 0);
        idle(32'hFFFF_FFFC, 0, 32'h0, 1, 1);
        // Correct direction but wrong target is a mispredict.
        step(32'h200, 0, 0, 1, 1, 32'h200, 1, 32'h310, 1, 32'h300, 0, 32'h204, 1, 32'h310, 1, 1);
        idle(32'h200, 1, 32'h310, 2, 2);

        begin
            int budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
